// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word load-store FSM with read-modify-write for sub-word stores
// Ports: clk, reset (async, active-high); req_* CPU request with valid/ready handshake;
// resp_* one-cycle completion pulse with extended load data and error flag;
// mem_* word-indexed memory port (mem_r_data is combinational from mem_addr).
module load_store_unit #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  output logic        mem_write_en,
  input  logic [31:0] mem_r_data
);
  typedef enum logic [2:0] {IDLE, ACCESS, RMW_READ, RMW_WRITE, RESP} state_t;
  state_t      r_state;
  logic        r_write, r_unsigned, r_err;
  logic [1:0]  r_size, r_off;
  logic [31:0] r_addr, r_wbuf, r_rdata;
  logic        w_err;
  logic [4:0]  w_sh;
  logic [31:0] w_lane, w_load, w_mask, w_merge;
  assign w_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                 ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  assign w_sh   = {r_off, 3'b000};
  assign w_lane = mem_r_data >> w_sh;
  assign w_load = r_size == 2'b00 ? {{24{!r_unsigned && w_lane[7]}}, w_lane[7:0]} :
                  r_size == 2'b01 ? {{16{!r_unsigned && w_lane[15]}}, w_lane[15:0]} : w_lane;
  assign w_mask  = (r_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
  // r_wbuf still holds the right-justified store data while in RMW_READ
  assign w_merge = (mem_r_data & ~w_mask) | ((r_wbuf << w_sh) & w_mask);
  assign req_ready    = r_state == IDLE;
  assign resp_valid   = r_state == RESP;
  assign resp_rdata   = r_rdata;
  assign resp_err     = r_err;
  assign mem_addr     = r_addr;
  assign mem_w_data   = r_wbuf;
  // Write strobe comes purely from registered state, so it cannot glitch
  assign mem_write_en = (r_state == ACCESS && r_write) || r_state == RMW_WRITE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= 2'b00;
      r_off      <= 2'b00;
      r_addr     <= 32'h0;
      r_wbuf     <= 32'h0;
      r_rdata    <= 32'h0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_write    <= req_write;
          r_size     <= req_size;
          r_unsigned <= req_unsigned;
          r_off      <= req_addr[1:0];
          r_addr     <= {2'b00, req_addr[31:2]};
          r_wbuf     <= req_wdata;
          if (w_err) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
            r_state <= RESP;
          end else begin
            r_state <= (req_write && req_size != 2'b10) ? RMW_READ : ACCESS;
          end
        end
        ACCESS: begin
          r_rdata <= r_write ? 32'h0 : w_load;
          r_err   <= 1'b0;
          r_state <= RESP;
        end
        RMW_READ: begin
          r_wbuf  <= w_merge;
          r_state <= RMW_WRITE;
        end
        RMW_WRITE: begin
          r_rdata <= 32'h0;
          r_err   <= 1'b0;
          r_state <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table, reset/back-to-back sequences and random traffic vs byte-array model
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_w_data, mem_r_data;
  logic        resp_valid, resp_err, mem_write_en;
  logic [31:0] mem [128];
  logic [7:0]  ref_mem [512];
  int          n_cmp = 0, n_fail = 0, wr_cnt = 0, resp_cnt = 0;
  logic [31:0] wr_addr = 32'h0;
  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, wdata, rd;
    logic        err;
    int          lat;
  } vec_t;
  typedef struct {logic w; logic [1:0] sz; logic uns; logic [31:0] addr, wdata;} req_t;
  typedef struct {logic [31:0] rd; logic err;} exp_t;
  vec_t tab [15];

  load_store_unit #(.MEM_WORDS(128)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_write_en(mem_write_en), .mem_r_data(mem_r_data)
  );

  always #5 clk = ~clk;
  assign mem_r_data = (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_write_en) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      if (mem_addr < 32'd128) mem[mem_addr[6:0]] <= mem_w_data;
    end
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed model: returns expected response and applies stores to ref_mem
  function automatic void model(input logic w, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err, output int lat);
    int n;
    longint v;
    n   = 1 << sz;
    err = sz == 2'd3 || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0) ||
          (addr / 4 >= 128);
    rd  = 32'h0;
    lat = err ? 1 : (w && sz != 2'd2) ? 3 : 2;
    if (err) return;
    if (w) begin
      for (int b = 0; b < n; b++) ref_mem[addr + b] = 8'((wdata >> (8 * b)) & 32'hFF);
    end else begin
      v = 0;
      for (int b = 0; b < n; b++) v = v | (longint'(ref_mem[addr + b]) << (8 * b));
      if (!uns && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
      rd = v[31:0];
    end
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input logic err, input int lat, input string nm);
    int w0, l;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    chk({nm, ".ready"}, 32'(req_ready), 32'd1);
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_unsigned = 1'($urandom);
    l = 1;
    while (!resp_valid && l < 8) begin
      @(posedge clk);
      #1;
      l++;
    end
    chk({nm, ".lat"}, 32'(l), 32'(lat));
    chk({nm, ".rdata"}, resp_rdata, rd);
    chk({nm, ".err"}, 32'(resp_err), 32'(err));
    chk({nm, ".wr_cnt"}, 32'(wr_cnt - w0), (w && !err) ? 32'd1 : 32'd0);
    if (w && !err) chk({nm, ".wr_addr"}, wr_addr, addr >> 2);
    @(posedge clk);
    #1;
    chk({nm, ".pulse_end"}, {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd, m4, a;
    logic        e;
    int          lat, w0, r0, i, cyc;
    logic [1:0]  sz;
    req_t        bq [8];
    exp_t        eq [$];
    exp_t        ex;
    tab[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2};
    tab[1]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0, 2};
    tab[2]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h000000DE, 1'b0, 2};
    tab[3]  = '{1'b0, 2'd1, 1'b0, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0, 2};
    tab[4]  = '{1'b1, 2'd1, 1'b0, 32'h12,  32'h00001234, 32'h0,        1'b0, 3};
    tab[5]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h1234BEEF, 1'b0, 2};
    tab[6]  = '{1'b0, 2'd2, 1'b0, 32'h11,  32'h0,        32'h0,        1'b1, 1};
    tab[7]  = '{1'b0, 2'd1, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1, 1};
    tab[8]  = '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1, 1};
    tab[9]  = '{1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344, 32'h0,        1'b1, 1};
    tab[10] = '{1'b1, 2'd0, 1'b0, 32'h11,  32'hFFFFFF55, 32'h0,        1'b0, 3};
    tab[11] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h123455EF, 1'b0, 2};
    tab[12] = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        32'h00001234, 1'b0, 2};
    tab[13] = '{1'b1, 2'd2, 1'b0, 32'h1FC, 32'hCAFEF00D, 32'h0,        1'b0, 2};
    tab[14] = '{1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0,        32'hCAFEF00D, 1'b0, 2};
    for (int k = 0; k < 128; k++) begin
      mem[k] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4 * k + b] = 8'(mem[k] >> (8 * b));
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    chk("rst.ready", {31'h0, req_ready}, 32'h1);
    chk("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst.mem_we", {31'h0, mem_write_en}, 32'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_w_data", mem_w_data, 32'h0);
    chk("rst.rdata", resp_rdata, 32'h0);
    chk("rst.err", {31'h0, resp_err}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      model(tab[k].w, tab[k].sz, tab[k].uns, tab[k].addr, tab[k].wdata, rd, e, lat);
      do_req(tab[k].w, tab[k].sz, tab[k].uns, tab[k].addr, tab[k].wdata,
             tab[k].rd, tab[k].err, tab[k].lat, $sformatf("tab%0d", k));
    end
    // Reset while a byte store sits in RMW_READ: nothing may be written or answered
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h000000AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    w0 = wr_cnt; r0 = resp_cnt; m4 = mem[4];
    #1 reset = 1'b1;
    #1;
    chk("midrst.ready", {31'h0, req_ready}, 32'h1);
    chk("midrst.mem_we", {31'h0, mem_write_en}, 32'h0);
    chk("midrst.mem_addr", mem_addr, 32'h0);
    chk("midrst.resp_valid", {31'h0, resp_valid}, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst.wr_cnt", 32'(wr_cnt - w0), 32'h0);
    chk("midrst.resp_cnt", 32'(resp_cnt - r0), 32'h0);
    chk("midrst.mem4", mem[4], m4);
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, e, lat);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, e, lat, "post_rst");
    // Back-to-back: req_valid held high, fields scrambled while the unit is busy
    for (int k = 0; k < 8; k++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 527);
      if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'd2) ? 32'd3 : (sz == 2'd1) ? 32'd1 : 32'd0);
      bq[k] = '{1'($urandom), sz, 1'($urandom), a, $urandom};
    end
    r0 = resp_cnt; i = 0; cyc = 0;
    while ((i < 8 || eq.size() != 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (req_ready && i < 8) begin
        req_valid = 1'b1; req_write = bq[i].w; req_size = bq[i].sz;
        req_unsigned = bq[i].uns; req_addr = bq[i].addr; req_wdata = bq[i].wdata;
        model(bq[i].w, bq[i].sz, bq[i].uns, bq[i].addr, bq[i].wdata, rd, e, lat);
        eq.push_back('{rd, e});
        i++;
      end else begin
        req_valid = i < 8; req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      end
      @(posedge clk);
      #1;
      if (resp_valid) begin
        if (eq.size() == 0) chk("b2b.extra_resp", 32'h1, 32'h0);
        else begin
          ex = eq.pop_front();
          chk("b2b.rdata", resp_rdata, ex.rd);
          chk("b2b.err", {31'h0, resp_err}, {31'h0, ex.err});
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b.timeout", 32'(cyc < 200), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b.resp_cnt", 32'(resp_cnt - r0), 32'd8);
    for (int k = 0; k < 150; k++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 527);
      if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'd2) ? 32'd3 : (sz == 2'd1) ? 32'd1 : 32'd0);
      begin
        logic w, u;
        logic [31:0] wd;
        w = 1'($urandom); u = 1'($urandom); wd = $urandom;
        model(w, sz, u, a, wd, rd, e, lat);
        do_req(w, sz, u, a, wd, rd, e, lat, $sformatf("rnd%0d", k));
      end
    end
    for (int k = 0; k < 128; k++)
      chk($sformatf("mem%0d", k), mem[k],
          {ref_mem[4 * k + 3], ref_mem[4 * k + 2], ref_mem[4 * k + 1], ref_mem[4 * k]});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: LOAD_STORE_UNIT

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 128, giving the number of 32-bit words in the attached data memory; valid word indices are 0..MEM_WORDS-1.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  CPU access request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-008 SHALL have port req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  request was rejected; qualified by resp_valid.
REQ-014 SHALL have port mem_addr  output  32  word index to memory, = req_addr >> 2.
REQ-015 SHALL have port mem_w_data  output  32  word written to memory.
REQ-016 SHALL have port mem_write_en  output  1  memory write strobe; memory writes on the clk edge while it is high.
REQ-017 SHALL have port mem_r_data  input  32  memory read data; combinational from mem_addr.

Function
REQ-018 SHALL implement the states IDLE, ACCESS, RMW_READ, RMW_WRITE and RESP.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted on a clk edge where req_valid and req_ready are both 1.
REQ-020 SHALL register all req_* fields at acceptance; later changes on the req_* inputs SHALL be ignored until the unit returns to IDLE.
REQ-021 SHALL use little-endian byte lanes: byte offset k = req_addr[1:0] occupies bits [8k+7:8k]; halfword offset 2 occupies bits [31:16].
REQ-022 SHALL flag an error, perform no memory write, and go IDLE -> RESP for any of: req_size = 11; halfword with req_addr[0] = 1; word with req_addr[1:0] != 0; (req_addr >> 2) >= MEM_WORDS.
REQ-023 SHALL handle word loads, word stores and all sub-word loads as IDLE -> ACCESS -> RESP.
REQ-024 SHALL, in ACCESS for a store, drive mem_w_data = wdata and mem_write_en = 1.
REQ-025 SHALL, in ACCESS for a load, capture mem_r_data, then extract the lane and extend it into resp_rdata.
REQ-026 SHALL handle sub-word stores as IDLE -> RMW_READ -> RMW_WRITE -> RESP.
REQ-027 SHALL, in RMW_READ, capture mem_r_data into a merge register.
REQ-028 SHALL, in RMW_WRITE, drive the merged word (untouched lanes preserved, target lane = low bits of wdata) on mem_w_data with mem_write_en = 1.
REQ-029 SHALL hold mem_addr stable from ACCESS/RMW_READ through RESP.
REQ-030 SHALL decode mem_write_en from the state register only, so it is high for exactly one cycle per legal store and never glitches.
REQ-031 SHALL give latency from the acceptance edge to resp_valid high of 2 cycles (loads, word stores), 3 cycles (sub-word stores) or 1 cycle (errors).
REQ-032 SHALL assert resp_valid for exactly one cycle, in RESP, and then return to IDLE; back-to-back requests SHALL therefore be spaced by at least one IDLE cycle.
REQ-033 SHALL hold resp_rdata and resp_err until the next response.

Reset
REQ-034 SHALL, on reset assertion, immediately force state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_addr = 0, mem_w_data = 0 and mem_write_en = 0, independent of clk.
REQ-035 SHALL abandon any operation in progress when reset is asserted mid-operation: no write SHALL occur after reset asserts, and no response SHALL be issued for it.
REQ-036 SHALL accept a new request on the first clk edge after reset deasserts if req_valid = 1.

Verification
REQ-037 SHALL cover: after reset, store word 0xDEADBEEF at byte address 0x10 -> mem_write_en high for 1 cycle with mem_addr = 4; resp_valid 2 cycles after acceptance with resp_err = 0.
REQ-038 SHALL cover: load byte at 0x13, signed -> resp_rdata = 0xFFFFFFDE; the same access unsigned -> 0x000000DE; load halfword at 0x10, signed -> 0xFFFFBEEF.
REQ-039 SHALL cover: store halfword 0x1234 at 0x12, then load word at 0x10 -> 0x1234BEEF; the store's response arrives 3 cycles after acceptance.
REQ-040 SHALL cover: load word at 0x11, load halfword at 0x13, req_size = 11, and store word at 0x200 with MEM_WORDS = 128 -> each gives resp_err = 1, resp_rdata = 0, mem_write_en never high, response 1 cycle after acceptance.
REQ-041 SHALL cover: reset asserted during RMW_READ of store byte 0xAA at 0x10 -> mem_write_en stays 0, memory word 4 unchanged, no resp_valid, req_ready = 1 immediately.
REQ-042 SHALL cover: req_valid held high continuously with changing fields -> each request accepted only in IDLE, in order, with one resp_valid pulse per request.
